bus_cycle_ctrl: RTL and testbench
=================================

// Module: bus_cycle_ctrl
// PURPOSE
//  Sits directly downstream of processor_8088 on the multiplexed local bus.
//  Demultiplexes ad/a using ale, decodes rd_n/wr_n/iom into one system-side
//  request/ack transaction per byte strobe, inserts wait states, returns read
//  data onto ad, and drives ready back to the CPU. Feeds memory/IO decoders.
// PARAMETERS
//  MEM_WAIT  0  minimum wait cycles between sys_req rise and completion, memory cycles
//  IO_WAIT   1  minimum wait cycles for I/O cycles
//  CNT_W     3  width of the wait-state counter; MEM_WAIT/IO_WAIT < 2**CNT_W
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  ale        in   1   address latch enable from CPU
//  a          in   20  CPU address bus
//  iom        in   1   1 = I/O, 0 = memory
//  rd_n       in   1   CPU read strobe, active low
//  wr_n       in   1   CPU write strobe, active low
//  den_n      in   1   data enable, active low
//  dtr        in   1   1 = CPU drives data
//  ad_in      in   8   value currently on ad (CPU side)
//  ad_out     out  8   read data to drive onto ad
//  ad_oe      out  1   tristate enable for ad_out
//  ready      out  1   1 = current cycle complete
//  sys_addr   out  20  latched address
//  sys_wdata  out  8   latched write data
//  sys_we     out  1   1 = write transaction
//  sys_io     out  1   1 = I/O space
//  sys_req    out  1   transaction request, held until accepted
//  sys_ack    in   1   slave done; rdata valid in same cycle for reads
//  sys_rdata  in   8   read data from slave
// BEHAVIOUR
//  Reset: sys_addr=0, sys_wdata=0, sys_we=0, sys_io=0, sys_req=0, ad_out=0, ad_oe=0, ready=1, FSM=IDLE, counter=0.
//  Address latch: sys_addr<=a and sys_io<=iom on every clk edge where ale=1, in any state.
//    ale in a non-IDLE state aborts the current transaction: sys_req drops and the FSM returns to ADDR.
//  FSM states:
//   IDLE: ale=1 -> ADDR.
//   ADDR: rd_n=0 -> REQ with sys_we=0. wr_n=0 -> REQ with sys_we=1, sys_wdata<=ad_in.
//     Both strobes low: the write wins.
//     Neither strobe low for 4 cycles -> IDLE.
//   REQ: sys_req=1, ready=0, counter increments each cycle.
//     Done when sys_ack=1 and counter>=wait, where wait = sys_io ? IO_WAIT : MEM_WAIT.
//     On done: latch sys_rdata into ad_out (reads) and go to DATA, with sys_req deasserted the next cycle.
//     sys_ack seen before the wait count is reached: the ack is remembered, and done fires when the count is reached.
//   DATA: ready=1. ad_oe = ~sys_we & ~rd_n & ~den_n.
//     On strobe release (rd_n&wr_n) -> IDLE, counter cleared, ad_oe=0.
//     Each new byte strobe (CPU second byte, addr+1) follows strobe release: falling strobe with no ale -> REQ.
//     For that second byte, sys_addr increments by 1 and wraps modulo 2**20 (fffff -> 00000).
//  Latency: sys_req rises 1 cycle after the strobe falls. ready and read data are valid 1 cycle after done.
//  ad_oe is never 1 when dtr=1 or ale=1 (bus-contention guard, combinational).
//  sys_ack outside REQ is ignored.
// STRUCTURE
//  Shared package/defines.v: FSM state encodings (BC_IDLE/BC_ADDR/BC_REQ/BC_DATA), default wait constants.
//  One sub-module: the existing counter (#(CNT_W)) for wait states. All else is flat in this module.
// TESTING
//  Mem read: ale with a=ffff0, iom=0, rd_n low, ack after 2 cycles with rdata=ea
//    -> sys_addr=ffff0, sys_we=0, ad_out=ea, ad_oe=1 while rd_n=0, ready low until done.
//  IO write: a=00061, iom=1, ad_in=5a, wr_n low, ack immediate, IO_WAIT=1
//    -> sys_wdata=5a, sys_io=1, done after counter>=1, ad_oe stays 0.
//  Two-byte read: strobe, release, strobe, no ale, base a=fffff
//    -> second sys_addr=00000 (wrap), two separate sys_req pulses.
//  Abort: ale asserted during REQ -> sys_req falls next cycle, new address latched, FSM=ADDR.
//  Reset mid-REQ: rst pulsed -> all outputs return to reset values immediately; later ack ignored.
//  Contention: dtr=1 during DATA on a read -> ad_oe=0.

Source files
------------

// File: rtl/bus_cycle_ctrl_pkg.sv
// rtl/bus_cycle_ctrl_pkg.sv - shared state encodings and default wait constants for bus_cycle_ctrl
package bus_cycle_ctrl_pkg;

    typedef enum logic [1:0] {
        BC_IDLE = 2'd0,
        BC_ADDR = 2'd1,
        BC_REQ  = 2'd2,
        BC_DATA = 2'd3
    } bc_state_e;

    localparam int DEF_MEM_WAIT = 0;
    localparam int DEF_IO_WAIT  = 1;
    localparam int DEF_CNT_W    = 3;

    // Cycles an address phase may sit with no strobe before it is given up.
    localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

endpackage

// File: rtl/bus_cycle_ctrl_counter.sv
// rtl/bus_cycle_ctrl_counter.sv - saturating wait-state counter with synchronous clear
module bus_cycle_ctrl_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    // Saturating keeps "count >= wait" true while a slave is slow to ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - 8088 local-bus demux and system-side request/ack cycle controller
module bus_cycle_ctrl
    import bus_cycle_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = DEF_MEM_WAIT,
    parameter int IO_WAIT  = DEF_IO_WAIT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ale,
    input  logic [19:0] a,
    input  logic        iom,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        den_n,
    input  logic        dtr,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic        ready,
    output logic [19:0] sys_addr,
    output logic [7:0]  sys_wdata,
    output logic        sys_we,
    output logic        sys_io,
    output logic        sys_req,
    input  logic        sys_ack,
    input  logic [7:0]  sys_rdata
);

    localparam logic [CNT_W-1:0] MEM_WAIT_C = CNT_W'(MEM_WAIT);
    localparam logic [CNT_W-1:0] IO_WAIT_C  = CNT_W'(IO_WAIT);

    bc_state_e        state_q;
    logic [19:0]      addr_q;
    logic [7:0]       wdata_q;
    logic [7:0]       ad_out_q;
    logic             we_q;
    logic             io_q;
    logic             req_q;
    logic             ready_q;
    logic             ack_q;
    logic             arm_q;
    logic [1:0]       idle_q;
    logic [CNT_W-1:0] cnt_q;

    logic strobe_d;
    logic wait_met_d;
    logic done_d;
    logic cnt_clr_d;
    logic cnt_inc_d;

    assign strobe_d   = ~rd_n | ~wr_n;
    assign wait_met_d = cnt_q >= (io_q ? IO_WAIT_C : MEM_WAIT_C);
    assign done_d     = (state_q == BC_REQ) && !ale && (sys_ack || ack_q) && wait_met_d;
    assign cnt_inc_d  = (state_q == BC_REQ);
    assign cnt_clr_d  = (state_q != BC_REQ) || ale;

    bus_cycle_ctrl_counter #(.CNT_W(CNT_W)) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr_d),
        .inc_i   (cnt_inc_d),
        .count_o (cnt_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BC_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            ad_out_q <= '0;
            we_q     <= 1'b0;
            io_q     <= 1'b0;
            req_q    <= 1'b0;
            ready_q  <= 1'b1;
            ack_q    <= 1'b0;
            arm_q    <= 1'b0;
            idle_q   <= '0;
        end else if (ale) begin
            // A new address phase always wins, aborting whatever was in flight.
            addr_q  <= a;
            io_q    <= iom;
            state_q <= BC_ADDR;
            req_q   <= 1'b0;
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            arm_q   <= 1'b0;
            idle_q  <= '0;
        end else begin
            case (state_q)
                BC_IDLE: begin
                    // Follow-on byte of the same bus cycle: no new ale, address steps by one.
                    if (arm_q && strobe_d) begin
                        state_q <= BC_REQ;
                        addr_q  <= addr_q + 20'd1;
                        we_q    <= ~wr_n;
                        if (!wr_n) begin
                            wdata_q <= ad_in;
                        end
                        req_q   <= 1'b1;
                        ready_q <= 1'b0;
                        ack_q   <= 1'b0;
                        arm_q   <= 1'b0;
                    end
                end
                BC_ADDR: begin
                    if (strobe_d) begin
                        state_q <= BC_REQ;
                        we_q    <= ~wr_n;
                        if (!wr_n) begin
                            wdata_q <= ad_in;
                        end
                        req_q   <= 1'b1;
                        ready_q <= 1'b0;
                        ack_q   <= 1'b0;
                    end else if (idle_q == ADDR_TIMEOUT) begin
                        state_q <= BC_IDLE;
                    end else begin
                        idle_q <= idle_q + 2'd1;
                    end
                end
                BC_REQ: begin
                    if (sys_ack && !we_q) begin
                        ad_out_q <= sys_rdata;
                    end
                    if (done_d) begin
                        state_q <= BC_DATA;
                        req_q   <= 1'b0;
                        ready_q <= 1'b1;
                        ack_q   <= 1'b0;
                    end else if (sys_ack) begin
                        ack_q <= 1'b1;
                    end
                end
                BC_DATA: begin
                    if (!strobe_d) begin
                        state_q <= BC_IDLE;
                        arm_q   <= 1'b1;
                    end
                end
                default: state_q <= BC_IDLE;
            endcase
        end
    end

    // The dtr/ale terms guard against driving ad while the CPU owns it.
    assign ad_oe = (state_q == BC_DATA) & ~we_q & ~rd_n & ~den_n & ~dtr & ~ale;

    assign ad_out    = ad_out_q;
    assign ready     = ready_q;
    assign sys_addr  = addr_q;
    assign sys_wdata = wdata_q;
    assign sys_we    = we_q;
    assign sys_io    = io_q;
    assign sys_req   = req_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb/tb_bus_cycle_ctrl.sv - self-checking bench for bus_cycle_ctrl
module tb_bus_cycle_ctrl;

    logic        clk;
    logic        rst;
    logic        ale;
    logic [19:0] a;
    logic        iom;
    logic        rd_n;
    logic        wr_n;
    logic        den_n;
    logic        dtr;
    logic [7:0]  ad_in;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic        ready;
    logic [19:0] sys_addr;
    logic [7:0]  sys_wdata;
    logic        sys_we;
    logic        sys_io;
    logic        sys_req;
    logic        sys_ack;
    logic [7:0]  sys_rdata;

    int total;
    int bad;

    bus_cycle_ctrl #(.MEM_WAIT(0), .IO_WAIT(1), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .ale       (ale),
        .a         (a),
        .iom       (iom),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .den_n     (den_n),
        .dtr       (dtr),
        .ad_in     (ad_in),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .ready     (ready),
        .sys_addr  (sys_addr),
        .sys_wdata (sys_wdata),
        .sys_we    (sys_we),
        .sys_io    (sys_io),
        .sys_req   (sys_req),
        .sys_ack   (sys_ack),
        .sys_rdata (sys_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        io;
        logic        wr;
        logic [19:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
        int          dly;
        int          exp_len;
    } txn_vec_t;

    typedef struct {
        logic dtr;
        logic den_n;
        logic rd_n;
        logic ale;
        logic exp_oe;
    } oe_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic txn_start(input logic do_ale, input logic io, input logic wr,
                             input logic [19:0] addr, input logic [7:0] wd,
                             input logic [19:0] exp_addr, input logic exp_io);
        if (do_ale) begin
            ale = 1'b1;
            a   = addr;
            iom = io;
            @(negedge clk);
            ale = 1'b0;
            a   = 20'($urandom);
            iom = 1'($urandom);
        end
        if (wr) begin
            wr_n  = 1'b0;
            dtr   = 1'b1;
            ad_in = wd;
        end else begin
            rd_n  = 1'b0;
            dtr   = 1'b0;
            den_n = 1'b0;
        end
        @(negedge clk);
        chk("req_rise", 32'(sys_req), 32'd1);
        chk("ready_low", 32'(ready), 32'd0);
        chk("sys_addr", 32'(sys_addr), 32'(exp_addr));
        chk("sys_we", 32'(sys_we), 32'(wr));
        chk("sys_io", 32'(sys_io), 32'(exp_io));
        if (wr) chk("sys_wdata", 32'(sys_wdata), 32'(wd));
    endtask

    task automatic txn_wait(input int dly, input logic [7:0] rdv, input int exp_len, input logic wr);
        int len;
        len = 0;
        while (sys_req === 1'b1 && len < 24) begin
            sys_ack   = (len == dly);
            sys_rdata = (len == dly) ? rdv : 8'($urandom);
            @(negedge clk);
            len++;
        end
        sys_ack = 1'b0;
        chk("req_len", 32'(len), 32'(exp_len));
        chk("ready_done", 32'(ready), 32'd1);
        if (!wr) begin
            chk("rdata", 32'(ad_out), 32'(rdv));
            chk("oe_read", 32'(ad_oe), 32'd1);
        end else begin
            chk("oe_write", 32'(ad_oe), 32'd0);
        end
    endtask

    task automatic txn_release();
        rd_n  = 1'b1;
        wr_n  = 1'b1;
        den_n = 1'b1;
        dtr   = 1'b0;
        @(negedge clk);
        chk("req_low", 32'(sys_req), 32'd0);
        chk("oe_release", 32'(ad_oe), 32'd0);
        chk("ready_release", 32'(ready), 32'd1);
    endtask

    task automatic addr_phase(input string name, input int k, input logic exp_req);
        ale = 1'b1;
        a   = 20'h0f0f0;
        iom = 1'b0;
        @(negedge clk);
        ale = 1'b0;
        repeat (k) @(negedge clk);
        rd_n  = 1'b0;
        den_n = 1'b0;
        @(negedge clk);
        chk(name, 32'(sys_req), 32'(exp_req));
        if (sys_req) begin
            sys_ack = 1'b1;
            @(negedge clk);
            sys_ack = 1'b0;
        end
        rd_n  = 1'b1;
        den_n = 1'b1;
        @(negedge clk);
    endtask

    txn_vec_t    tv[6];
    oe_vec_t     ov[6];
    logic [19:0] m_addr;
    logic        m_io;
    logic        second;
    logic        r_wr;
    logic [7:0]  r_wd;
    logic [7:0]  r_rd;
    int          r_dly;
    int          r_wait;

    initial begin
        total = 0;
        bad   = 0;

        tv[0] = '{io:1'b0, wr:1'b0, addr:20'hffff0, wd:8'h00, rd:8'hea, dly:2, exp_len:3};
        tv[1] = '{io:1'b1, wr:1'b1, addr:20'h00061, wd:8'h5a, rd:8'h00, dly:0, exp_len:2};
        tv[2] = '{io:1'b0, wr:1'b1, addr:20'h00100, wd:8'h33, rd:8'h00, dly:0, exp_len:1};
        tv[3] = '{io:1'b1, wr:1'b0, addr:20'h003f8, wd:8'h00, rd:8'hc3, dly:3, exp_len:4};
        tv[4] = '{io:1'b0, wr:1'b0, addr:20'h80000, wd:8'h00, rd:8'h01, dly:0, exp_len:1};
        tv[5] = '{io:1'b1, wr:1'b1, addr:20'h00000, wd:8'hff, rd:8'h00, dly:1, exp_len:2};

        ov[0] = '{dtr:1'b0, den_n:1'b0, rd_n:1'b0, ale:1'b0, exp_oe:1'b1};
        ov[1] = '{dtr:1'b1, den_n:1'b0, rd_n:1'b0, ale:1'b0, exp_oe:1'b0};
        ov[2] = '{dtr:1'b0, den_n:1'b1, rd_n:1'b0, ale:1'b0, exp_oe:1'b0};
        ov[3] = '{dtr:1'b0, den_n:1'b0, rd_n:1'b1, ale:1'b0, exp_oe:1'b0};
        ov[4] = '{dtr:1'b0, den_n:1'b0, rd_n:1'b0, ale:1'b1, exp_oe:1'b0};
        ov[5] = '{dtr:1'b1, den_n:1'b1, rd_n:1'b0, ale:1'b0, exp_oe:1'b0};

        rst = 1'b1; ale = 1'b0; a = '0; iom = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
        den_n = 1'b1; dtr = 1'b0; ad_in = '0; sys_ack = 1'b0; sys_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_addr", 32'(sys_addr), 32'd0);
        chk("rst_wdata", 32'(sys_wdata), 32'd0);
        chk("rst_we", 32'(sys_we), 32'd0);
        chk("rst_io", 32'(sys_io), 32'd0);
        chk("rst_req", 32'(sys_req), 32'd0);
        chk("rst_ad_out", 32'(ad_out), 32'd0);
        chk("rst_ad_oe", 32'(ad_oe), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            txn_start(1'b1, tv[i].io, tv[i].wr, tv[i].addr, tv[i].wd, tv[i].addr, tv[i].io);
            txn_wait(tv[i].dly, tv[i].rd, tv[i].exp_len, tv[i].wr);
            txn_release();
        end

        // Contention guard while a read sits in its data phase.
        txn_start(1'b1, 1'b0, 1'b0, 20'h12340, 8'h00, 20'h12340, 1'b0);
        txn_wait(1, 8'h9c, 2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            dtr = ov[i].dtr; den_n = ov[i].den_n; rd_n = ov[i].rd_n; ale = ov[i].ale;
            #1;
            chk("oe_guard", 32'(ad_oe), 32'(ov[i].exp_oe));
            dtr = 1'b0; den_n = 1'b0; rd_n = 1'b0; ale = 1'b0;
            @(negedge clk);
        end
        txn_release();

        // Two-byte read wrapping the address space.
        txn_start(1'b1, 1'b0, 1'b0, 20'hfffff, 8'h00, 20'hfffff, 1'b0);
        txn_wait(0, 8'h11, 1, 1'b0);
        txn_release();
        txn_start(1'b0, 1'b0, 1'b0, 20'h0, 8'h00, 20'h00000, 1'b0);
        txn_wait(2, 8'h22, 3, 1'b0);
        txn_release();

        // Abort: new ale while the request is outstanding.
        txn_start(1'b1, 1'b0, 1'b0, 20'h12345, 8'h00, 20'h12345, 1'b0);
        ale = 1'b1; a = 20'habcde; iom = 1'b1;
        @(negedge clk);
        ale = 1'b0; rd_n = 1'b1; den_n = 1'b1;
        chk("abort_req", 32'(sys_req), 32'd0);
        chk("abort_addr", 32'(sys_addr), 32'habcde);
        chk("abort_io", 32'(sys_io), 32'd1);
        chk("abort_ready", 32'(ready), 32'd1);
        repeat (5) @(negedge clk);

        addr_phase("addr_hold3", 3, 1'b1);
        addr_phase("addr_timeout4", 4, 1'b0);

        // Reset in the middle of a request; a late ack must be ignored.
        txn_start(1'b1, 1'b0, 1'b0, 20'h0abcd, 8'h00, 20'h0abcd, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstmid_req", 32'(sys_req), 32'd0);
        chk("rstmid_ready", 32'(ready), 32'd1);
        chk("rstmid_addr", 32'(sys_addr), 32'd0);
        chk("rstmid_oe", 32'(ad_oe), 32'd0);
        @(negedge clk);
        rst = 1'b0; sys_ack = 1'b1; sys_rdata = 8'h77;
        @(negedge clk);
        sys_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_req", 32'(sys_req), 32'd0);
        chk("late_ack_ad_out", 32'(ad_out), 32'd0);
        rd_n = 1'b1; den_n = 1'b1;
        @(negedge clk);

        // Random transactions against a transaction-level model.
        m_addr = '0;
        m_io   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            second = (i > 0) && ($urandom_range(0, 2) == 0);
            if (second) begin
                m_addr = m_addr + 20'd1;
            end else begin
                m_addr = 20'($urandom);
                m_io   = 1'($urandom);
            end
            r_wr   = 1'($urandom);
            r_wd   = 8'($urandom);
            r_rd   = 8'($urandom);
            r_dly  = $urandom_range(0, 5);
            r_wait = m_io ? 1 : 0;
            txn_start(!second, m_io, r_wr, m_addr, r_wd, m_addr, m_io);
            txn_wait(r_dly, r_rd, ((r_dly > r_wait) ? r_dly : r_wait) + 1, r_wr);
            txn_release();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
